// File: rtl/ceyloniac_pkg.sv
// Shared definitions for the ceyloniac fetch path: FSM encoding and the
// address/data width defaults also used by the IR and instruction memory.
package ceyloniac_pkg;

    localparam int unsigned RAM_ADDR_WIDTH_DEF = 32;
    localparam int unsigned RAM_DATA_WIDTH_DEF = 32;
    localparam int unsigned COUNT_WIDTH_DEF    = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    // Instructions are word-aligned; any set low address bit is a fault.
    function automatic logic pc_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/ceyloniac_fetch_timeout_counter.sv
// Counts WAIT cycles without mem_ready; expired is high during the cycle
// that is the LIMIT-th consecutive wait cycle.
module ceyloniac_fetch_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] count_q;

    assign expired = (count_q == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/ceyloniac_instruction_fetch_unit.sv
// Multi-cycle instruction fetch controller: PC -> memory read -> IR strobe.
// Optional wait-cycle timeout is enabled by defining CEYLONIAC_FETCH_TIMEOUT_EN.
module ceyloniac_instruction_fetch_unit
    import ceyloniac_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int unsigned RAM_DATA_WIDTH = RAM_DATA_WIDTH_DEF,
    parameter int unsigned COUNT_WIDTH    = COUNT_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_req,
    input  logic                      fetch_flush,
    input  logic [RAM_ADDR_WIDTH-1:0] pc,
    output logic                      mem_read,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    input  logic                      mem_ready,
    input  logic [RAM_DATA_WIDTH-1:0] mem_rdata,
    output logic                      ir_write,
    output logic [RAM_DATA_WIDTH-1:0] instruction,
    output logic                      fetch_busy,
    output logic                      fetch_done,
    output logic                      fetch_err,
    output logic [COUNT_WIDTH-1:0]    fetch_count
);

    fetch_state_e              state_q, state_d;
    logic                      mem_read_q, mem_read_d;
    logic [RAM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [RAM_DATA_WIDTH-1:0] instruction_q, instruction_d;
    logic                      ir_write_q, ir_write_d;
    logic                      fetch_done_q, fetch_done_d;
    logic                      fetch_err_q, fetch_err_d;
    logic [COUNT_WIDTH-1:0]    fetch_count_q, fetch_count_d;
    logic                      timeout_hit;

`ifdef CEYLONIAC_FETCH_TIMEOUT_EN
    ceyloniac_fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .enable  ((state_q == ST_WAIT) && !mem_ready),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            instruction_q <= '0;
            ir_write_q    <= 1'b0;
            fetch_done_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_addr_q    <= mem_addr_d;
            instruction_q <= instruction_d;
            ir_write_q    <= ir_write_d;
            fetch_done_q  <= fetch_done_d;
            fetch_err_q   <= fetch_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_addr_d    = mem_addr_q;
        instruction_d = instruction_q;
        ir_write_d    = 1'b0;
        fetch_done_d  = 1'b0;
        fetch_err_d   = 1'b0;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    if (pc_aligned(pc[1:0])) begin
                        mem_addr_d = pc;
                        mem_read_d = 1'b1;
                        state_d    = ST_WAIT;
                    end else begin
                        fetch_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Flush beats arriving data; arriving data beats timeout.
                if (fetch_flush) begin
                    mem_read_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (mem_ready) begin
                    instruction_d = mem_rdata;
                    mem_read_d    = 1'b0;
                    ir_write_d    = 1'b1;
                    state_d       = ST_WRITE;
                end else if (timeout_hit) begin
                    mem_read_d  = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (fetch_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    fetch_done_d  = 1'b1;
                    fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;
    assign instruction = instruction_q;
    assign ir_write    = ir_write_q;
    assign fetch_done  = fetch_done_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_count = fetch_count_q;
    assign fetch_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ceyloniac_instruction_fetch_unit.sv
// Self-checking bench for ceyloniac_instruction_fetch_unit: table vectors,
// randomized transactions against a transaction-level model, corner sequences.
module tb_ceyloniac_instruction_fetch_unit;

`ifdef CEYLONIAC_FETCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int MAXW       = TB_TIMEOUT - 1;
`else
    localparam int TB_TIMEOUT = 255;
    localparam int MAXW       = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        fetch_flush;
    logic [31:0] pc;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ir_write;
    logic [31:0] instruction;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_err;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic [31:0] last_instr = 32'h0;

    ceyloniac_instruction_fetch_unit #(
        .RAM_ADDR_WIDTH (32),
        .RAM_DATA_WIDTH (32),
        .COUNT_WIDTH    (16),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_flush (fetch_flush),
        .pc          (pc),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ir_write    (ir_write),
        .instruction (instruction),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        int          flush_at;   // -1 none, 0..waits during WAIT, 100 in WRITE
        bit          req_in_wait;
        int          exp_ir;
        int          exp_done;
        int          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string name);
        chk(name, {48'h0, fetch_count}, {48'h0, exp_count[15:0]});
    endtask

    task automatic run_fetch(input logic [31:0] a, input logic [31:0] d, input int waits,
                             input int flush_at, input bit req_in_wait,
                             output int ir_n, output int done_n, output int err_n);
        logic [31:0] junk;
        ir_n = 0; done_n = 0; err_n = 0;
        pc = a; fetch_req = 1'b1; fetch_flush = 1'b0; mem_ready = 1'b0;
        junk = $urandom; mem_rdata = junk;
        step();
        fetch_req = 1'b0; junk = $urandom; pc = junk;
        if (a[1:0] != 2'b00) begin
            err_n += int'(fetch_err);
            chk("misalign_err", 64'(fetch_err), 64'd1);
            chk("misalign_rd", 64'(mem_read), 64'd0);
            chk("misalign_busy", 64'(fetch_busy), 64'd0);
            step();
            err_n += int'(fetch_err);
            chk("misalign_err_end", 64'(fetch_err), 64'd0);
            chk("misalign_rd2", 64'(mem_read), 64'd0);
            chk_count("misalign_count");
            return;
        end
        for (int c = 0; c <= waits; c++) begin
            chk("wait_rd", 64'(mem_read), 64'd1);
            chk("wait_addr", 64'(mem_addr), 64'(a));
            chk("wait_busy", 64'(fetch_busy), 64'd1);
            chk("wait_ir", 64'(ir_write), 64'd0);
            ir_n += int'(ir_write);
            mem_ready = (c == waits);
            junk = $urandom;
            mem_rdata = (c == waits) ? d : junk;
            fetch_flush = (flush_at == c);
            fetch_req = req_in_wait ? junk[0] : 1'b0;
            step();
            mem_ready = 1'b0; fetch_flush = 1'b0; fetch_req = 1'b0;
            if (flush_at == c) begin
                ir_n += int'(ir_write); done_n += int'(fetch_done);
                chk("flush_rd", 64'(mem_read), 64'd0);
                chk("flush_ir", 64'(ir_write), 64'd0);
                chk("flush_busy", 64'(fetch_busy), 64'd0);
                chk("flush_instr_hold", 64'(instruction), 64'(last_instr));
                step();
                ir_n += int'(ir_write); done_n += int'(fetch_done);
                chk("flush_nodone", 64'(fetch_done), 64'd0);
                chk("flush_rd_idle", 64'(mem_read), 64'd0);
                chk_count("flush_count");
                return;
            end
        end
        ir_n += int'(ir_write);
        chk("write_ir", 64'(ir_write), 64'd1);
        chk("write_instr", 64'(instruction), 64'(d));
        chk("write_rd", 64'(mem_read), 64'd0);
        chk("write_done", 64'(fetch_done), 64'd0);
        chk("write_busy", 64'(fetch_busy), 64'd1);
        last_instr = d;
        fetch_flush = (flush_at == 100);
        step();
        fetch_flush = 1'b0;
        ir_n += int'(ir_write); done_n += int'(fetch_done);
        chk("post_write_ir", 64'(ir_write), 64'd0);
        if (flush_at == 100) begin
            chk("wflush_done", 64'(fetch_done), 64'd0);
            chk("wflush_busy", 64'(fetch_busy), 64'd0);
            chk_count("wflush_count");
            return;
        end
        exp_count++;
        chk("done_pulse", 64'(fetch_done), 64'd1);
        chk("done_busy", 64'(fetch_busy), 64'd1);
        chk("done_instr", 64'(instruction), 64'(d));
        chk_count("done_count");
        junk = $urandom;
        fetch_flush = junk[3];
        step();
        fetch_flush = 1'b0;
        done_n += int'(fetch_done);
        chk("done_end", 64'(fetch_done), 64'd0);
        chk("idle_busy", 64'(fetch_busy), 64'd0);
        chk_count("idle_count");
    endtask

    vec_t tbl[9];

    initial begin
        int ir_n, done_n, err_n;
        logic [31:0] r, a, d;
        int w, fk, fa, e_ir, e_done, e_err;

        tbl[0] = '{32'h0000_0040, 32'h8C22_0004, 0,  -1, 1'b0, 1, 1, 0};
        tbl[1] = '{32'h0000_0080, 32'h1234_5678, 3,  -1, 1'b1, 1, 1, 0};
        tbl[2] = '{32'h0000_0042, 32'h0,         0,  -1, 1'b0, 0, 0, 1};
        tbl[3] = '{32'h0000_0048, 32'hDEAD_BEEF, 2,   2, 1'b0, 0, 0, 0};
        tbl[4] = '{32'h0000_0044, 32'hCAFE_F00D, 0,  -1, 1'b0, 1, 1, 0};
        tbl[5] = '{32'h0000_0050, 32'hA5A5_A5A5, 1, 100, 1'b0, 1, 0, 0};
        tbl[6] = '{32'h0000_0043, 32'h0,         0,  -1, 1'b0, 0, 0, 1};
        tbl[7] = '{32'h0000_0060, 32'h0BAD_F00D, 1,   0, 1'b1, 0, 0, 0};
        tbl[8] = '{32'hFFFF_FFF1, 32'h0,         0,  -1, 1'b0, 0, 0, 1};

        reset = 1'b1; fetch_req = 1'b0; fetch_flush = 1'b0; pc = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", 64'(mem_read), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_ir", 64'(ir_write), 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_busy", 64'(fetch_busy), 64'd0);
        chk("rst_done", 64'(fetch_done), 64'd0);
        chk("rst_err", 64'(fetch_err), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        foreach (tbl[i]) begin
            run_fetch(tbl[i].addr, tbl[i].data, tbl[i].waits, tbl[i].flush_at,
                      tbl[i].req_in_wait, ir_n, done_n, err_n);
            chk("tbl_ir", 64'(ir_n), 64'(tbl[i].exp_ir));
            chk("tbl_done", 64'(done_n), 64'(tbl[i].exp_done));
            chk("tbl_err", 64'(err_n), 64'(tbl[i].exp_err));
            $display("vec %0d pc=%08h waits=%0d flush=%0d ir=%0d done=%0d err=%0d count=%0d",
                     i, tbl[i].addr, tbl[i].waits, tbl[i].flush_at, ir_n, done_n, err_n, fetch_count);
        end

        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            a = ($urandom_range(0, 9) < 8) ? {r[31:2], 2'b00} : {r[31:2], 2'b10};
            d = $urandom;
            w = $urandom_range(0, MAXW);
            fk = $urandom_range(0, 9);
            fa = (fk < 6) ? -1 : ((fk < 8) ? $urandom_range(0, w) : 100);
            e_err  = (a[1:0] != 2'b00) ? 1 : 0;
            e_ir   = (e_err == 0 && (fa == -1 || fa == 100)) ? 1 : 0;
            e_done = (e_err == 0 && fa == -1) ? 1 : 0;
            run_fetch(a, d, w, fa, r[0], ir_n, done_n, err_n);
            chk("rnd_ir", 64'(ir_n), 64'(e_ir));
            chk("rnd_done", 64'(done_n), 64'(e_done));
            chk("rnd_err", 64'(err_n), 64'(e_err));
            $display("rnd %0d pc=%08h waits=%0d flush=%0d ir=%0d done=%0d err=%0d count=%0d",
                     t, a, w, fa, ir_n, done_n, err_n, fetch_count);
        end

        // Asynchronous reset in the middle of WAIT, checked before any clock edge.
        chk("pre_reset_count_nonzero", 64'(fetch_count != 16'h0), 64'd1);
        pc = 32'h0000_0100; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        chk("mid_wait_rd", 64'(mem_read), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rd", 64'(mem_read), 64'd0);
        chk("async_ir", 64'(ir_write), 64'd0);
        chk("async_busy", 64'(fetch_busy), 64'd0);
        chk("async_count", 64'(fetch_count), 64'd0);
        chk("async_instr", 64'(instruction), 64'd0);
        exp_count = 0; last_instr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_reset_done", 64'(fetch_done), 64'd0);
        run_fetch(32'h0000_0044, 32'h2002_0001, 1, -1, 1'b0, ir_n, done_n, err_n);
        chk("post_reset_fetch_done", 64'(done_n), 64'd1);
        $display("post-reset fetch ir=%0d done=%0d count=%0d", ir_n, done_n, fetch_count);

`ifdef CEYLONIAC_FETCH_TIMEOUT_EN
        pc = 32'h0000_0200; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int c = 0; c < TB_TIMEOUT; c++) begin
            chk("to_wait_rd", 64'(mem_read), 64'd1);
            chk("to_wait_err", 64'(fetch_err), 64'd0);
            step();
        end
        chk("to_err", 64'(fetch_err), 64'd1);
        chk("to_rd", 64'(mem_read), 64'd0);
        chk("to_ir", 64'(ir_write), 64'd0);
        chk("to_busy", 64'(fetch_busy), 64'd0);
        step();
        chk("to_err_end", 64'(fetch_err), 64'd0);
        chk("to_no_ir", 64'(ir_write), 64'd0);
        $display("timeout fetch err observed after %0d wait cycles", TB_TIMEOUT);
`else
        pc = 32'h0000_0200; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int c = 0; c < 300; c++) begin
            chk("nto_rd", 64'(mem_read), 64'd1);
            chk("nto_err", 64'(fetch_err), 64'd0);
            step();
        end
        fetch_flush = 1'b1;
        step();
        fetch_flush = 1'b0;
        chk("nto_flush_rd", 64'(mem_read), 64'd0);
        chk("nto_flush_busy", 64'(fetch_busy), 64'd0);
        $display("no-timeout fetch held mem_read for 300 cycles then flushed");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
